audio_codec_master: RTL and testbench

AUDIO_CODEC_MASTER -- requirements
Module: audio_codec_master

---
 rtl/audio_codec_master.sv | 191 +++++++++++++++++++
 tb/tb_audio_codec_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_codec_master.sv
// Clock-master serial audio interface for a codec running in slave mode.
// Generates BCLK and both LRCK lines from CLOCK_50. Plays one stereo sample pair
// per 64-BCLK frame from a single-entry holding register, and captures one stereo
// pair per frame into a valid/ready output register. Left-justified, MSB first,
// 32 BCLK per channel slot.
module audio_codec_master #(
  parameter int BCLK_HALF_PERIOD = 16,
  parameter int AUDIO_DATA_WIDTH = 16
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [AUDIO_DATA_WIDTH-1:0] dac_left,
  input  logic [AUDIO_DATA_WIDTH-1:0] dac_right,
  input  logic                        dac_valid,
  output logic                        dac_ready,
  output logic [AUDIO_DATA_WIDTH-1:0] adc_left,
  output logic [AUDIO_DATA_WIDTH-1:0] adc_right,
  output logic                        adc_valid,
  input  logic                        adc_ready,
  output logic                        dac_underrun,
  output logic                        adc_overrun,
  output logic                        AUD_BCLK,
  output logic                        AUD_DACLRCK,
  output logic                        AUD_ADCLRCK,
  output logic                        AUD_DACDAT,
  input  logic                        AUD_ADCDAT
);

  localparam int         W         = AUDIO_DATA_WIDTH;
  localparam logic [7:0] DIV_LAST  = 8'(BCLK_HALF_PERIOD - 1);
  // Number of slot positions that carry sample data (W never exceeds the 32-bit slot).
  localparam logic [5:0] SLOT_BITS = 6'(W);

  // BCLK generation and frame position
  logic [7:0]   div_cnt;
  logic         bclk_tick;
  logic         bclk_rise;
  logic         bclk_fall;
  logic [5:0]   bit_cnt;
  logic [5:0]   bit_nxt;
  logic         frame_wrap;

  // Playback path
  logic [W-1:0] hold_l;
  logic [W-1:0] hold_r;
  logic         hold_valid;
  logic [W-1:0] dac_sh_l;
  logic [W-1:0] dac_sh_r;
  logic [W-1:0] load_l;
  logic [W-1:0] load_r;
  logic [W-1:0] cur_l;
  logic [W-1:0] cur_r;
  logic         dac_bit_nxt;

  // Capture path
  logic [W-1:0] adc_sh_l;
  logic [W-1:0] adc_sh_r;
  logic         adc_slot_active;
  logic         cap_vld_p1;

  // Picks the MSB-first bit for slot position k; positions past the sample width are 0.
  function automatic logic slot_bit(input logic [W-1:0] word, input logic [4:0] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (k == 5'(W - 1 - i)) b = word[i];
    end
    return b;
  endfunction

  // Edge qualifiers: a tick with BCLK low is a rising toggle, with BCLK high a falling one.
  always_comb begin
    bclk_tick  = (div_cnt == DIV_LAST);
    bclk_rise  = bclk_tick & ~AUD_BCLK;
    bclk_fall  = bclk_tick & AUD_BCLK;
    bit_nxt    = bit_cnt + 6'd1;
    frame_wrap = bclk_fall & (bit_cnt == 6'd63);
  end

  // Next DAC bit: at the frame wrap the freshly loaded pair supplies bit 0 directly.
  always_comb begin
    load_l          = hold_valid ? hold_l : '0;
    load_r          = hold_valid ? hold_r : '0;
    cur_l           = frame_wrap ? load_l : dac_sh_l;
    cur_r           = frame_wrap ? load_r : dac_sh_r;
    dac_bit_nxt     = bit_nxt[5] ? slot_bit(cur_r, bit_nxt[4:0])
                                 : slot_bit(cur_l, bit_nxt[4:0]);
    adc_slot_active = ({1'b0, bit_cnt[4:0]} < SLOT_BITS);
  end

  // Divider, BCLK, bit counter and LRCK; LRCK moves together with the falling BCLK toggle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt     <= 8'd0;
      AUD_BCLK    <= 1'b0;
      bit_cnt     <= 6'd0;
      AUD_DACLRCK <= 1'b1;
      AUD_ADCLRCK <= 1'b1;
    end else begin
      if (bclk_tick) begin
        div_cnt  <= 8'd0;
        AUD_BCLK <= ~AUD_BCLK;
      end else begin
        div_cnt  <= div_cnt + 8'd1;
      end
      if (bclk_fall) begin
        bit_cnt     <= bit_nxt;
        AUD_DACLRCK <= ~bit_nxt[5];
        AUD_ADCLRCK <= ~bit_nxt[5];
      end
    end
  end

  // Holding register handshake; drained into the frame registers at every frame wrap.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hold_valid <= 1'b0;
      dac_ready  <= 1'b1;
    end else begin
      if (dac_valid && dac_ready) begin
        hold_valid <= 1'b1;
        dac_ready  <= 1'b0;
      end else if (frame_wrap && hold_valid) begin
        hold_valid <= 1'b0;
        dac_ready  <= 1'b1;
      end
    end
  end

  // Holding data carries no reset; it is only ever consumed qualified by hold_valid.
  always_ff @(posedge CLOCK_50) begin
    if (dac_valid && dac_ready) begin
      hold_l <= dac_left;
      hold_r <= dac_right;
    end
  end

  // Frame registers, serial DAC output and underrun pulse (none for the post-reset frame).
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dac_sh_l     <= '0;
      dac_sh_r     <= '0;
      AUD_DACDAT   <= 1'b0;
      dac_underrun <= 1'b0;
    end else begin
      dac_underrun <= frame_wrap & ~hold_valid;
      if (frame_wrap) begin
        dac_sh_l <= load_l;
        dac_sh_r <= load_r;
      end
      if (bclk_fall) AUD_DACDAT <= dac_bit_nxt;
    end
  end

  // ADC sampling on rising BCLK; flags the last right-channel bit for transfer next cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      adc_sh_l   <= '0;
      adc_sh_r   <= '0;
      cap_vld_p1 <= 1'b0;
    end else begin
      cap_vld_p1 <= bclk_rise & (bit_cnt == 6'd47);
      if (bclk_rise && adc_slot_active) begin
        if (bit_cnt[5]) adc_sh_r <= {adc_sh_r[W-2:0], AUD_ADCDAT};
        else            adc_sh_l <= {adc_sh_l[W-2:0], AUD_ADCDAT};
      end
    end
  end

  // ---- stage p1: capture register; a new capture wins over a same-cycle acceptance ----
  // Output register: capture overwrites, overrun only if the old pair was never taken.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      adc_left    <= '0;
      adc_right   <= '0;
      adc_valid   <= 1'b0;
      adc_overrun <= 1'b0;
    end else begin
      adc_overrun <= 1'b0;
      if (cap_vld_p1) begin
        adc_left    <= adc_sh_l;
        adc_right   <= adc_sh_r;
        adc_valid   <= 1'b1;
        adc_overrun <= adc_valid & ~adc_ready;
      end else if (adc_valid && adc_ready) begin
        adc_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_codec_master.sv
// Bench for audio_codec_master: frame-level stimulus against two instances
// (half period 16 and 2), pin timing derived from elapsed cycles, codec model on ADCDAT.
module tb_audio_codec_master;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        reset = 1'b1;
  logic [15:0] dac_left = '0, dac_right = '0;
  logic        dac_valid = 1'b0, adc_ready = 1'b0, AUD_ADCDAT = 1'b0;

  logic        s_drdy, s_avld, s_und, s_ovr, s_bclk, s_dl, s_al, s_dat;
  logic        f_drdy, f_avld, f_und, f_ovr, f_bclk, f_dl, f_al, f_dat;
  logic [15:0] s_aleft, s_aright, f_aleft, f_aright;

  audio_codec_master #(.BCLK_HALF_PERIOD(16), .AUDIO_DATA_WIDTH(16)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .dac_left(dac_left), .dac_right(dac_right),
    .dac_valid(dac_valid), .dac_ready(s_drdy), .adc_left(s_aleft), .adc_right(s_aright),
    .adc_valid(s_avld), .adc_ready(adc_ready), .dac_underrun(s_und), .adc_overrun(s_ovr),
    .AUD_BCLK(s_bclk), .AUD_DACLRCK(s_dl), .AUD_ADCLRCK(s_al), .AUD_DACDAT(s_dat),
    .AUD_ADCDAT(AUD_ADCDAT));

  audio_codec_master #(.BCLK_HALF_PERIOD(2), .AUDIO_DATA_WIDTH(16)) dut_fast (
    .CLOCK_50(CLOCK_50), .reset(reset), .dac_left(dac_left), .dac_right(dac_right),
    .dac_valid(dac_valid), .dac_ready(f_drdy), .adc_left(f_aleft), .adc_right(f_aright),
    .adc_valid(f_avld), .adc_ready(adc_ready), .dac_underrun(f_und), .adc_overrun(f_ovr),
    .AUD_BCLK(f_bclk), .AUD_DACLRCK(f_dl), .AUD_ADCLRCK(f_al), .AUD_DACDAT(f_dat),
    .AUD_ADCDAT(AUD_ADCDAT));

  logic        sel = 1'b0;
  int          hp  = 16;
  logic        o_drdy, o_avld, o_und, o_ovr, o_bclk, o_dl, o_al, o_dat;
  logic [15:0] o_aleft, o_aright;
  assign o_drdy   = sel ? f_drdy   : s_drdy;
  assign o_avld   = sel ? f_avld   : s_avld;
  assign o_und    = sel ? f_und    : s_und;
  assign o_ovr    = sel ? f_ovr    : s_ovr;
  assign o_bclk   = sel ? f_bclk   : s_bclk;
  assign o_dl     = sel ? f_dl     : s_dl;
  assign o_al     = sel ? f_al     : s_al;
  assign o_dat    = sel ? f_dat    : s_dat;
  assign o_aleft  = sel ? f_aleft  : s_aleft;
  assign o_aright = sel ? f_aright : s_aright;

  int          n;
  int          passed = 0;
  int          total  = 0;
  logic [15:0] cod_l [64];
  logic [15:0] cod_r [64];

  typedef struct {
    logic        w;
    logic [15:0] wl, wr, cl, cr;
    int          mode;            // 0: never ready, 1: ready all frame, 2: ready only at capture
    logic [15:0] edl, edr;
    int          eund;
    logic [15:0] eal, ear;
    int          eovr;
  } vec_t;
  vec_t tbl [5];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, n);
  endfunction

  // Expected pins after nn clock edges since reset: every hp cycles BCLK toggles,
  // every second toggle advances the bit, 64 bits per frame.
  function automatic void exp_pins(input int nn, input logic [15:0] dl, input logic [15:0] dr,
                                   output logic bclk, output logic lrck, output logic dat);
    int t, b, k;
    t    = nn / hp;
    b    = (t / 2) % 64;
    k    = b % 32;
    bclk = t[0];
    lrck = (b < 32);
    dat  = (k < 16) ? ((b < 32) ? dl[15-k] : dr[15-k]) : 1'b0;
  endfunction

  // Codec: drives the bit for the current slot, junk (1) in unused slot positions.
  function automatic logic codec_bit(input int nn);
    int t, f, b, k;
    t = nn / hp;
    f = ((t / 2) / 64) % 64;
    b = (t / 2) % 64;
    k = b % 32;
    if (k >= 16) return 1'b1;
    return (b < 32) ? cod_l[f][15-k] : cod_r[f][15-k];
  endfunction

  task automatic step();
    @(negedge CLOCK_50);
    n++;
    AUD_ADCDAT = codec_bit(n);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge CLOCK_50);
    reset = 1'b0;
    n = 0;
    AUD_ADCDAT = codec_bit(0);
  endtask

  task automatic run_frame(input int f, input logic w, input logic [15:0] wl, input logic [15:0] wr,
                           input int mode, input logic [15:0] edl, input logic [15:0] edr,
                           input int eund, input logic [15:0] eal, input logic [15:0] ear,
                           input int eovr);
    int   cap, pin_err, und, ovr;
    logic eb, el, ed;
    cap = 95 * hp + 1;
    pin_err = 0; und = 0; ovr = 0;
    for (int c = 0; c < 128 * hp; c++) begin
      exp_pins(n, edl, edr, eb, el, ed);
      if (o_bclk !== eb || o_dl !== el || o_al !== el || o_dat !== ed) pin_err++;
      und += int'(o_und);
      ovr += int'(o_ovr);
      if (c == 0) adc_ready = (mode == 1);
      if (mode == 2) adc_ready = (c == cap - 1);
      if (c == 1 && mode == 1) check($sformatf("f%0d adc_valid_after_ready", f), o_avld, 0);
      if (c == 100 && w) begin
        check($sformatf("f%0d dac_ready_idle", f), o_drdy, 1);
        dac_left = wl; dac_right = wr; dac_valid = 1'b1;
      end
      if (c == 101 && w) begin
        check($sformatf("f%0d dac_ready_full", f), o_drdy, 0);
        dac_valid = 1'b0;
      end
      if (c == cap) begin
        check($sformatf("f%0d adc_valid_capture", f), o_avld, 1);
        check($sformatf("f%0d adc_left", f), o_aleft, eal);
        check($sformatf("f%0d adc_right", f), o_aright, ear);
      end
      if (c == cap + 1) check($sformatf("f%0d adc_valid_post", f), o_avld, (mode != 1));
      step();
    end
    check($sformatf("f%0d pin_mismatch_cycles", f), pin_err, 0);
    check($sformatf("f%0d dac_underrun_pulses", f), und, eund);
    check($sformatf("f%0d adc_overrun_pulses", f), ovr, eovr);
  endtask

  initial begin
    logic        rw [32];
    logic [15:0] rl [32], rr [32];
    int          rm [32];
    int          pending, nf;

    //       w     wl        wr        cl        cr        mode edl       edr       und eal       ear       ovr
    tbl[0] = '{1'b1, 16'hA5C3, 16'h0FF0, 16'h8001, 16'h7FFE, 1, 16'h0000, 16'h0000, 0, 16'h8001, 16'h7FFE, 0};
    tbl[1] = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 16'hABCD, 0, 16'hA5C3, 16'h0FF0, 0, 16'h1234, 16'hABCD, 0};
    tbl[2] = '{1'b1, 16'hFFFF, 16'h0001, 16'h5555, 16'hAAAA, 0, 16'h0000, 16'h0000, 1, 16'h5555, 16'hAAAA, 1};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0F0F, 16'hF0F0, 2, 16'hFFFF, 16'h0001, 0, 16'h0F0F, 16'hF0F0, 0};
    tbl[4] = '{1'b0, 16'h0000, 16'h0000, 16'h8000, 16'h0001, 1, 16'h0000, 16'h0000, 1, 16'h8000, 16'h0001, 0};

    // Directed frames on the default-rate instance.
    sel = 1'b0; hp = 16;
    for (int i = 0; i < 64; i++) begin cod_l[i] = 16'h0; cod_r[i] = 16'h0; end
    for (int i = 0; i < 5; i++) begin cod_l[i] = tbl[i].cl; cod_r[i] = tbl[i].cr; end
    do_reset(4);
    check("reset bclk", o_bclk, 0);
    check("reset lrck", {o_dl, o_al}, 2'b11);
    check("reset dac_ready", o_drdy, 1);
    check("reset adc_valid", o_avld, 0);
    check("reset dacdat", o_dat, 0);
    for (int i = 0; i < 5; i++)
      run_frame(i, tbl[i].w, tbl[i].wl, tbl[i].wr, tbl[i].mode, tbl[i].edl, tbl[i].edr,
                tbl[i].eund, tbl[i].eal, tbl[i].ear, tbl[i].eovr);

    // Reset in the middle of a frame while a sample is held and a capture is pending.
    for (int i = 0; i < 4; i++) begin cod_l[i] = 16'($urandom); cod_r[i] = 16'($urandom); end
    do_reset(2);
    run_frame(0, 1'b0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, cod_l[0], cod_r[0], 0);
    for (int c = 0; c < 41 * hp; c++) begin
      if (c == 100) begin dac_left = 16'h1234; dac_right = 16'h5678; dac_valid = 1'b1; end
      if (c == 101) dac_valid = 1'b0;
      step();
    end
    check("prereset dac_ready", o_drdy, 0);
    check("prereset adc_valid", o_avld, 1);
    check("prereset bclk", o_bclk, 1);
    do_reset(1);
    check("midreset bclk", o_bclk, 0);
    check("midreset lrck", {o_dl, o_al}, 2'b11);
    check("midreset dac_ready", o_drdy, 1);
    check("midreset adc_valid", o_avld, 0);
    check("midreset adc_left", o_aleft, 16'h0);
    run_frame(0, 1'b0, 16'h0, 16'h0, 1, 16'h0, 16'h0, 0, cod_l[0], cod_r[0], 0);
    run_frame(1, 1'b0, 16'h0, 16'h0, 1, 16'h0, 16'h0, 1, cod_l[1], cod_r[1], 0);

    // Randomized frames on the fast instance, first frame fixed to the reference pattern.
    sel = 1'b1; hp = 2; nf = 24;
    for (int i = 0; i < nf; i++) begin
      rw[i] = 1'($urandom_range(0, 1));
      rl[i] = 16'($urandom); rr[i] = 16'($urandom);
      rm[i] = $urandom_range(0, 2);
      cod_l[i] = 16'($urandom); cod_r[i] = 16'($urandom);
    end
    rw[0] = 1'b1; rl[0] = 16'hA5C3; rr[0] = 16'h0FF0; rm[0] = 1;
    cod_l[0] = 16'h8001; cod_r[0] = 16'h7FFE;
    do_reset(3);
    pending = 0;
    for (int f = 0; f < nf; f++) begin
      logic [15:0] edl, edr;
      int          eund, eovr;
      edl  = (f > 0 && rw[f-1]) ? rl[f-1] : 16'h0;
      edr  = (f > 0 && rw[f-1]) ? rr[f-1] : 16'h0;
      eund = (f > 0 && !rw[f-1]) ? 1 : 0;
      eovr = (pending != 0 && rm[f] == 0) ? 1 : 0;
      run_frame(f, rw[f], rl[f], rr[f], rm[f], edl, edr, eund, cod_l[f], cod_r[f], eovr);
      pending = (rm[f] != 1) ? 1 : 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
